seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-seg digits; successor to single-digit hex decoder.
//  Latches a packed hex word, scans one digit per slot, decodes nibble -> segments (hex 0-F), drives digit enables.
//  Tear-free update (new value takes effect only at frame boundary), leading-zero blanking, anti-ghost guard cycle.
//  Sits between board-level display pins and any datapath that wants a multi-digit hex readout.
// PARAMETERS
//  NUM_DIGITS      4      digits scanned; >=1
//  SCAN_DIV        50000  clk cycles per digit slot; >=2
//  SEG_ACTIVE_LOW  0      1: invert seg_out (lit segment = 0)
//  DIG_ACTIVE_LOW  0      1: invert dig_out (selected digit = 0)
//  BLINK_FRAMES    64     frames per blink half-period (SEVSEG_BLINK_EN only); >=1
// PORTS
//  clk         in   1             clock, rising edge
//  rst_n       in   1             asynchronous reset, active-low
//  value_in    in   4*NUM_DIGITS  packed hex; digit k = value_in[4k+3:4k], digit NUM_DIGITS-1 = MS
//  dp_in       in   NUM_DIGITS    decimal point per digit
//  load        in   1             capture value_in/dp_in into pending register this cycle
//  blank_zero  in   1             enable leading-zero blanking (sampled live)
//  blink_mask  in   NUM_DIGITS    digits to blink (present only with SEVSEG_BLINK_EN)
//  seg_out     out  8             {dp,a,b,c,d,e,f,g}, bit7=dp, bit6=a ... bit0=g
//  dig_out     out  NUM_DIGITS    one-hot digit enable
//  frame_done  out  1             1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  Reset: div_cnt=0, dig_idx=0, pending/active regs=0, seg_out=all-off, dig_out=all-off, frame_done=0.
//   all-off = 8'h00 (8'hFF if SEG_ACTIVE_LOW); digit all-off likewise per DIG_ACTIVE_LOW. Reset mid-scan: immediate.
//  Scan: div_cnt counts 0..SCAN_DIV-1 then wraps; at div_cnt==SCAN_DIV-1, dig_idx <= (dig_idx==NUM_DIGITS-1)?0:dig_idx+1.
//  Frame boundary = div_cnt==SCAN_DIV-1 && dig_idx==NUM_DIGITS-1; frame_done asserted (registered) the following cycle.
//  Load: load=1 writes pending<=value_in/dp_in; at frame boundary active<=pending. Back-to-back loads: last one wins.
//   load coincident with frame boundary: value_in bypasses pending straight into active (visible next frame, not one later).
//  Guard: whenever div_cnt==0, dig_out=all-off (one dead cycle per slot to suppress ghosting); seg_out still driven.
//  Decode: nibble 0-F -> standard hex glyphs (0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=72,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47 on bits6:0).
//  Leading-zero blank (blank_zero=1): from MS digit downward, digits whose nibble==0 and all more-significant nibbles==0
//   show segments a-g off; digit 0 never blanked (value 0 shows "0"). dp bit still follows active dp.
//  Outputs registered: seg_out/dig_out reflect dig_idx/div_cnt of previous cycle (latency 1 clk); no combinational path in->out.
//  Polarity inversion applied last, after blanking/guard.
// CONFIGURATION
//  SEVSEG_BLINK_EN defined: blink_mask port exists; blink_phase toggles every BLINK_FRAMES frame boundaries (reset 0 = on);
//   when blink_phase=1, masked digits show all segments incl. dp off; dig_out scanning unchanged.
//  SEVSEG_BLINK_EN undefined: no blink_mask port, no blink counter; behaviour identical to blink_mask=0.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4, active-high unless stated)
//  Reset held, then released -> seg_out=8'h00, dig_out=4'b0000, frame_done=0; first dig_out=4'b0001 at div_cnt==1.
//  load value_in=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged until frame_done; next frame digits F,A,2(+dp),1
//   give seg_out 47,77,ED,30 in slots 0..3; frame_done pulses every 16 clk.
//  blank_zero=1, load 16'h0005 -> digits 3..1 seg a-g off, digit0 seg_out=5B; load 16'h0000 -> digit0 shows 7E.
//  load asserted exactly on frame-boundary cycle with 16'h3333 -> next frame shows 3333 (bypass), not one frame later.
//  rst_n dropped during slot 2 of a frame -> outputs all-off asynchronously; after release active=0, scan restarts at digit 0.
//  SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value 0 -> seg_out=8'h81 in slot 0, dig_out=4'b1110; guard cycle dig_out=4'b1111.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex driver for NUM_DIGITS seven-segment digits with tear-free frame updates.
// Optional digit blinking is compiled in when SEVSEG_BLINK_EN is defined.
module seven_seg_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0,
   parameter int BLINK_FRAMES   = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_zero,
`ifdef SEVSEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_out,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF =
      (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [CNT_W-1:0]        div_cnt_reg;
   logic [DIG_W-1:0]        dig_idx_reg;
   logic [4*NUM_DIGITS-1:0] pend_val_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg;
   logic [4*NUM_DIGITS-1:0] act_val_reg;
   logic [NUM_DIGITS-1:0]   act_dp_reg;
   logic [7:0]              seg_reg;
   logic [NUM_DIGITS-1:0]   dig_reg;
   logic                    frame_done_reg;

   logic                    slot_end;
   logic                    frame_end;
   logic [NUM_DIGITS-1:0]   nib_zero;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [NUM_DIGITS-1:0]   blank_vec;
   logic [NUM_DIGITS-1:0]   blink_vec;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    cur_blink;
   logic [7:0]              seg_raw;
   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   dig_raw;
   logic [NUM_DIGITS-1:0]   dig_next;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h7E;
         4'h1: g = 7'h30;
         4'h2: g = 7'h6D;
         4'h3: g = 7'h79;
         4'h4: g = 7'h33;
         4'h5: g = 7'h5B;
         4'h6: g = 7'h5F;
         4'h7: g = 7'h72;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h7B;
         4'hA: g = 7'h77;
         4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;
         4'hD: g = 7'h3D;
         4'hE: g = 7'h4F;
         default: g = 7'h47;
      endcase
      return g;
   endfunction

   assign slot_end  = (div_cnt_reg == LAST_CNT);
   assign frame_end = slot_end && (dig_idx_reg == LAST_DIG);

   // lead_zero[k]: nibble k and every more-significant nibble are zero.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         assign nib_zero[gi] = (act_val_reg[4*gi +: 4] == 4'h0);
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign lead_zero[gi] = nib_zero[gi];
         end else begin : g_low
            assign lead_zero[gi] = nib_zero[gi] & lead_zero[gi+1];
         end
         if (gi == 0) begin : g_d0
            assign blank_vec[gi] = 1'b0;
         end else begin : g_dn
            assign blank_vec[gi] = lead_zero[gi];
         end
      end
   endgenerate

`ifdef SEVSEG_BLINK_EN
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

   logic [BLK_W-1:0] blink_cnt_reg;
   logic             blink_phase_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else if (frame_end) begin
         if (blink_cnt_reg == LAST_BLK) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   assign blink_vec = blink_phase_reg ? blink_mask : {NUM_DIGITS{1'b0}};
`else
   assign blink_vec = {NUM_DIGITS{1'b0}};
`endif

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      dig_raw   = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (dig_idx_reg == DIG_W'(k)) begin
            cur_nib   = act_val_reg[4*k +: 4];
            cur_dp    = act_dp_reg[k];
            cur_blank = blank_vec[k];
            cur_blink = blink_vec[k];
            // Slot's first cycle is a dead cycle so the previous digit's segments never ghost.
            dig_raw[k] = (div_cnt_reg != '0);
         end
      end

      seg_raw = {cur_dp, hex_glyph(cur_nib)};
      if (blank_zero && cur_blank) begin
         seg_raw[6:0] = 7'h00;
      end
      if (cur_blink) begin
         seg_raw = 8'h00;
      end

      seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      dig_next = (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_reg <= '0;
         dig_idx_reg <= '0;
      end else begin
         div_cnt_reg <= slot_end ? '0 : div_cnt_reg + 1'b1;
         if (slot_end) begin
            dig_idx_reg <= (dig_idx_reg == LAST_DIG) ? '0 : dig_idx_reg + 1'b1;
         end
      end
   end

   // A load landing on the frame boundary goes straight to active so it is not delayed a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val_reg <= '0;
         pend_dp_reg  <= '0;
         act_val_reg  <= '0;
         act_dp_reg   <= '0;
      end else begin
         if (load) begin
            pend_val_reg <= value_in;
            pend_dp_reg  <= dp_in;
         end
         if (frame_end) begin
            act_val_reg <= load ? value_in : pend_val_reg;
            act_dp_reg  <= load ? dp_in : pend_dp_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_reg        <= SEG_OFF;
         dig_reg        <= DIG_OFF;
         frame_done_reg <= 1'b0;
      end else begin
         seg_reg        <= seg_next;
         dig_reg        <= dig_next;
         frame_done_reg <= frame_end;
      end
   end

   assign seg_out    = seg_reg;
   assign dig_out    = dig_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4 clocks per slot) plus an active-low instance.
module tb_seven_seg_scan;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_zero;
   logic [7:0]  seg_out;
   logic [3:0]  dig_out;
   logic        frame_done;

   logic [15:0] low_value;
   logic [3:0]  low_dp;
   logic        low_load;
   logic        low_blank;
   logic [7:0]  low_seg;
   logic [3:0]  low_dig;
   logic        low_fd;

   int checks = 0;
   int errors = 0;

   seven_seg_scan #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load),
      .blank_zero(blank_zero), .seg_out(seg_out), .dig_out(dig_out), .frame_done(frame_done)
   );

   seven_seg_scan #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLINK_FRAMES(2)
   ) u_low (
      .clk(clk), .rst_n(rst_n), .value_in(low_value), .dp_in(low_dp), .load(low_load),
      .blank_zero(low_blank), .seg_out(low_seg), .dig_out(low_dig), .frame_done(low_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (frame_done !== 1'b1 && n < 40);
      chk({tag, "_frame_done_seen"}, {7'd0, frame_done}, 8'h01);
   endtask

   // Checks one full frame, one clock at a time, starting just after the frame_done edge.
   task automatic check_slots(input string tag, input logic [31:0] segs);
      int k;
      int ph;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         k  = (i - 1) / 4;
         ph = (i - 1) % 4;
         chk($sformatf("%s_seg_s%0d_c%0d", tag, k, ph), seg_out, segs[8*k +: 8]);
         chk($sformatf("%s_dig_s%0d_c%0d", tag, k, ph), {4'd0, dig_out},
             (ph == 0) ? 8'h00 : (8'h01 << k));
         chk($sformatf("%s_fd_c%0d", tag, i), {7'd0, frame_done}, (i == 16) ? 8'h01 : 8'h00);
      end
      $display("frame %s checked: seg slots 0..3 = %h %h %h %h", tag,
               segs[7:0], segs[15:8], segs[23:16], segs[31:24]);
   endtask

   initial begin
      rst_n      = 1'b0;
      value_in   = 16'h0000;
      dp_in      = 4'b0000;
      load       = 1'b0;
      blank_zero = 1'b0;
      low_value  = 16'h0000;
      low_dp     = 4'b0000;
      low_load   = 1'b0;
      low_blank  = 1'b0;

      // Reset state and the first scanned cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", seg_out, 8'h00);
      chk("rst_dig", {4'd0, dig_out}, 8'h00);
      chk("rst_fd", {7'd0, frame_done}, 8'h00);
      chk("rst_low_seg", low_seg, 8'hFF);
      chk("rst_low_dig", {4'd0, low_dig}, 8'h0F);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_guard_dig", {4'd0, dig_out}, 8'h00);
      chk("first_guard_seg", seg_out, 8'h7E);
      chk("low_guard_dig", {4'd0, low_dig}, 8'h0F);
      chk("low_guard_seg", low_seg, 8'h81);
      @(posedge clk);
      #1;
      chk("first_dig", {4'd0, dig_out}, 8'h01);
      chk("low_dig", {4'd0, low_dig}, 8'h0E);
      chk("low_seg", low_seg, 8'h81);
      $display("reset and first slot checked");

      // Mid-frame load must not tear the current frame
      wait_frame("pre12af");
      repeat (2) @(posedge clk);
      #1;
      value_in = 16'h12AF;
      dp_in    = 4'b0100;
      load     = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_old_seg", seg_out, 8'h7E);
      wait_frame("f12af");
      check_slots("v12af", {8'h30, 8'hED, 8'h77, 8'h47});

      // Leading-zero blanking, back-to-back loads (last wins)
      blank_zero = 1'b1;
      dp_in      = 4'b0000;
      value_in   = 16'h0007;
      load       = 1'b1;
      @(posedge clk);
      #1;
      value_in = 16'h0005;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_frame("f0005");
      check_slots("v0005", {8'h00, 8'h00, 8'h00, 8'h5B});

      value_in = 16'h0000;
      load     = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_frame("f0000");
      check_slots("v0000", {8'h00, 8'h00, 8'h00, 8'h7E});

      // Load exactly on the frame-boundary cycle bypasses pending
      repeat (15) @(posedge clk);
      #1;
      value_in = 16'h3333;
      load     = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("bypass_fd", {7'd0, frame_done}, 8'h01);
      check_slots("v3333", {8'h79, 8'h79, 8'h79, 8'h79});

      // Asynchronous reset during slot 2
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_seg", seg_out, 8'h00);
      chk("async_dig", {4'd0, dig_out}, 8'h00);
      chk("async_fd", {7'd0, frame_done}, 8'h00);
      chk("async_low_seg", low_seg, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_guard_dig", {4'd0, dig_out}, 8'h00);
      chk("restart_seg", seg_out, 8'h7E);
      @(posedge clk);
      #1;
      chk("restart_dig", {4'd0, dig_out}, 8'h01);
      wait_frame("fpostrst");
      check_slots("vpostrst", {8'h00, 8'h00, 8'h00, 8'h7E});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
